pipe_stage_hs: RTL

//  Parametrised, handshaked pipeline stage register, successor to the fixed ID->EX latch.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/sat_counter.sv | 29 ++
 rtl/pipe_stage_hs.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and field layout for the handshaked pipeline stage
//
// Purpose: state encoding for the stage FSM, default field widths and the
//          bit offsets used when packing ID/EX control and data fields.
// Ports:   none (package)
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int CTRL_W_DEF = 12;
    localparam int DATA_W_DEF = 116;

    // Control field: {RegWrite, MemToReg, MemWrite, MemRead, ALUSrc, RegDst, ALUfunc[5:0]}
    localparam int ALUFUNC_LSB  = 0;
    localparam int ALUFUNC_W    = 6;
    localparam int REGDST_BIT   = 6;
    localparam int ALUSRC_BIT   = 7;
    localparam int MEMREAD_BIT  = 8;
    localparam int MEMWRITE_BIT = 9;
    localparam int MEMTOREG_BIT = 10;
    localparam int REGWRITE_BIT = 11;

    // Data field: {regA, regB, SignIm, Ra, Rb, Rd, shamt}
    localparam int SHAMT_LSB  = 0;
    localparam int RD_LSB     = 5;
    localparam int RB_LSB     = 10;
    localparam int RA_LSB     = 15;
    localparam int SIGNIM_LSB = 20;
    localparam int REGB_LSB   = 52;
    localparam int REGA_LSB   = 84;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts qualifying cycles, sticks at all-ones instead of wrapping.
// Ports:   clk  - clock
//          clr  - synchronous active-high clear
//          inc  - count this cycle
//          q    - current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - handshaked pipeline stage register with optional skid entry
//
// Purpose: valid/ready pipeline register carrying a control field (forced to
//          zero when no entry is live) and a data field, with flush, an
//          optional skid entry and saturating bubble/stall counters.
// Ports:   clk, clr (sync active-high reset), flush (sync kill)
//          in_valid/in_ready, ctrl_d, data_d   - upstream side
//          out_valid/out_ready, ctrl_e, data_e - downstream side
//          bubble_cnt, stall_cnt               - performance counters
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [DATA_W-1:0] data_e,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit USE_SKID = (SKID_EN != 0);

    pipe_state_e       state_q,     state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // With a skid entry the ready is a pure function of state, breaking the
    // combinational ready chain; without it ready looks through to out_ready.
    generate
        if (USE_SKID) begin : g_skid_ready
            assign in_ready = (state_q != ST_SKID);
        end else begin : g_comb_ready
            assign in_ready = (state_q == ST_EMPTY) | out_ready;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d     = ST_FULL;
                    main_ctrl_d = ctrl_d;
                    main_data_d = data_d;
                end
            end
            ST_FULL: begin
                if (out_xfer && in_xfer) begin
                    main_ctrl_d = ctrl_d;
                    main_data_d = data_d;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer && USE_SKID) begin
                    state_d     = ST_SKID;
                    skid_ctrl_d = ctrl_d;
                    skid_data_d = data_d;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    state_d     = ST_FULL;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush overrides everything above: any accepted input is dropped and
        // held control is zeroed so a stale entry can never look like a live op.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Bubble = NOP downstream, so control is masked whenever nothing is live.
    assign ctrl_e = out_valid ? main_ctrl_q : '0;
    assign data_e = main_data_q;

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .clr (clr),
        .inc (~out_valid),
        .q   (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (clr),
        .inc (out_valid & ~out_ready),
        .q   (stall_cnt)
    );

endmodule
